// File: rtl/bsr_pkg.sv
// Shared types and constants for the BSR metadata path.
package bsr_pkg;

  localparam int META_COLIDX_BASE = 128;
  localparam int MAX_RD           = 8;
  localparam int TAG_ID_W         = $clog2(MAX_RD);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } meta_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-wide round-robin picker; the pointer register lives with the caller.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             upd_en,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any,
  output logic [PTR_W-1:0] next_ptr
);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    any      = 1'b0;
    next_ptr = ptr;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!any && req[i] && i == (int'(ptr) + k) % N) begin
          any    = 1'b1;
          gnt[i] = 1'b1;
          idx    = PTR_W'(i);
        end
      end
    end
    if (upd_en && any)
      next_ptr = (idx == PTR_W'(N - 1)) ? '0 : idx + 1'b1;
  end

endmodule

// File: rtl/bsr_meta_arbiter.sv
// Single-port arbiter for the BSR metadata BRAM: write priority, round-robin
// reads with bounded starvation, and a tag pipeline that routes read data back.
module bsr_meta_arbiter
  import bsr_pkg::*;
#(
  parameter int NUM_RD     = 2,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_gnt,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_gnt,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [TAG_ID_W-1:0] rr_ptr, rr_next, arb_idx;
  logic [NUM_RD-1:0]   arb_gnt, resp_oh;
  logic                arb_any, starve_hit, rd_win;
  logic [CNT_W-1:0]    starve_cnt;
  meta_tag_t           tag_q [RD_LAT];

  rr_arbiter #(.N(NUM_RD), .PTR_W(TAG_ID_W)) u_rr (
    .req      (rd_req),
    .ptr      (rr_ptr),
    .upd_en   (rd_win),
    .gnt      (arb_gnt),
    .idx      (arb_idx),
    .any      (arb_any),
    .next_ptr (rr_next)
  );

  // A write yields only once it has starved pending reads STARVE_MAX times.
  assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX)) && arb_any;
  assign wr_gnt     = !rst && wr_req && !starve_hit;
  assign rd_win     = !rst && arb_any && !wr_gnt;
  assign rd_gnt     = rd_win ? arb_gnt : '0;

  always_comb begin
    mem_en    = wr_gnt | rd_win;
    mem_we    = wr_gnt;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wr_gnt) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else begin
      for (int i = 0; i < NUM_RD; i++)
        if (rd_gnt[i]) mem_addr = rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      rr_ptr <= rr_next;
      if (rd_win || !arb_any)
        starve_cnt <= '0;
      else if (wr_gnt && starve_cnt != CNT_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // NOTE: the tag stages are control state, so reset clears them to drop in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= rd_win ? meta_tag_t'{valid: 1'b1, id: arb_idx} : '0;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    resp_oh = '0;
    for (int i = 0; i < NUM_RD; i++)
      if (tag_q[RD_LAT-1].valid && int'(tag_q[RD_LAT-1].id) == i) resp_oh[i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= resp_oh;
      rd_data  <= tag_q[RD_LAT-1].valid ? mem_rdata : '0;
    end
  end

endmodule
